// File: rtl/ins_fetch_unit_if.sv
// ins_fetch_unit_if: fetch-stage bus grouping PC feedback, stall/freeze controls, imem write port and fetch outputs.
interface ins_fetch_unit_if;
   logic [31:0] pc_in_0;
   logic [31:0] pc_in_1;
   logic        wait_for_next_in;
   logic        freeze_pc_in;
   logic        freeze_in;
   logic        ins_wr_en;
   logic [31:0] ins_wr_addr;
   logic [31:0] ins_wr_data;
   logic [31:0] npc_out;
   logic [31:0] ins_out;
   logic        cu_enable_out;
   logic        communication_enable_out;
   logic [18:0] communication_signal_out;
   modport master (
      output pc_in_0, pc_in_1, wait_for_next_in, freeze_pc_in, freeze_in,
             ins_wr_en, ins_wr_addr, ins_wr_data,
      input  npc_out, ins_out, cu_enable_out, communication_enable_out, communication_signal_out
   );
   modport slave (
      input  pc_in_0, pc_in_1, wait_for_next_in, freeze_pc_in, freeze_in,
             ins_wr_en, ins_wr_addr, ins_wr_data,
      output npc_out, ins_out, cu_enable_out, communication_enable_out, communication_signal_out
   );
endinterface

// File: rtl/ins_fetch_unit.sv
// ins_fetch_unit: fetch stage with internal word-addressed imem and communication-instruction decode.
// Define INS_FETCH_END_HALT_EN to make an End communication instruction halt fetch until reset.
module ins_fetch_unit #(
   parameter int MEM_DEPTH = 1024
) (
   input logic clock,
   input logic reset,
   ins_fetch_unit_if.slave bus
);
   localparam int AW = $clog2(MEM_DEPTH);
   logic [31:0] mem [MEM_DEPTH];
   logic [31:0] pc, pc_sel, ins_wire, ins_reg;
   logic        pc_choice, halted, advance, is_comm, unused_bits;
   assign pc_sel = pc_choice ? bus.pc_in_1 : bus.pc_in_0;
   assign ins_wire = mem[pc_sel[AW-1:0]];
   assign is_comm = &ins_wire[31:26];
   assign advance = ~(bus.wait_for_next_in | bus.freeze_pc_in | halted);
   assign bus.ins_out = bus.freeze_in ? 32'b0 : ins_reg;
   assign unused_bits = ^{pc, pc_sel[31:AW], bus.ins_wr_addr[31:AW]};
   always_ff @(posedge clock)
      if (bus.ins_wr_en) mem[bus.ins_wr_addr[AW-1:0]] <= bus.ins_wr_data;
   always_ff @(posedge clock)
      if (reset) begin
         pc                           <= '0;
         pc_choice                    <= 1'b1;
         ins_reg                      <= '0;
         bus.npc_out                  <= '0;
         bus.cu_enable_out            <= 1'b0;
         bus.communication_enable_out <= 1'b0;
         bus.communication_signal_out <= '0;
      end else if (advance) begin
         pc                           <= pc_sel;
         pc_choice                    <= 1'b0;
         ins_reg                      <= ins_wire;
         bus.npc_out                  <= pc_sel + 32'd1;
         bus.cu_enable_out            <= ~is_comm;
         bus.communication_enable_out <= is_comm;
         bus.communication_signal_out <= is_comm ? ins_wire[25:7] : 19'b0;
      end
`ifdef INS_FETCH_END_HALT_EN
   // End is a communication word whose type field (instr[25:24]) is 00
   always_ff @(posedge clock)
      halted <= reset ? 1'b0 : (halted | (advance & is_comm & (ins_wire[25:24] == 2'b00)));
`else
   assign halted = 1'b0;
`endif
endmodule

// File: tb/tb_ins_fetch_unit.sv
// tb_ins_fetch_unit: table-driven vectors with an expected-output scoreboard for ins_fetch_unit.
module tb_ins_fetch_unit;
   typedef struct {
      logic        rst;
      logic [31:0] p0, p1;
      logic        wt, fp, fz, we;
      logic [31:0] wa, wd;
      logic [31:0] e_npc, e_ins;
      logic        e_cu, e_ce;
      logic [18:0] e_sig;
   } vec_t;
   logic clock = 1'b0;
   logic reset = 1'b1;
   int vectors = 0;
   int miscompares = 0;
   vec_t tbl[$];
   vec_t sb[$];
   ins_fetch_unit_if bus();
   ins_fetch_unit #(.MEM_DEPTH(1024)) dut (.clock(clock), .reset(reset), .bus(bus));
   always #5 clock = ~clock;
   function automatic vec_t v(input logic rst, input logic [31:0] p0, p1, input logic wt, fp, fz, we,
                              input logic [31:0] wa, wd, e_npc, e_ins, input logic e_cu, e_ce,
                              input logic [18:0] e_sig);
      vec_t r;
      r.rst = rst; r.p0 = p0; r.p1 = p1; r.wt = wt; r.fp = fp; r.fz = fz; r.we = we;
      r.wa = wa; r.wd = wd; r.e_npc = e_npc; r.e_ins = e_ins; r.e_cu = e_cu; r.e_ce = e_ce;
      r.e_sig = e_sig;
      return r;
   endfunction
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask
   task automatic run(input vec_t r);
      vec_t e;
      reset = r.rst;
      bus.pc_in_0 = r.p0; bus.pc_in_1 = r.p1;
      bus.wait_for_next_in = r.wt; bus.freeze_pc_in = r.fp; bus.freeze_in = r.fz;
      bus.ins_wr_en = r.we; bus.ins_wr_addr = r.wa; bus.ins_wr_data = r.wd;
      sb.push_back(r);
      @(posedge clock);
      #1;
      e = sb.pop_front();
      chk("npc_out", bus.npc_out, e.e_npc);
      chk("ins_out", bus.ins_out, e.e_ins);
      chk("cu_enable_out", {31'b0, bus.cu_enable_out}, {31'b0, e.e_cu});
      chk("communication_enable_out", {31'b0, bus.communication_enable_out}, {31'b0, e.e_ce});
      chk("communication_signal_out", {13'b0, bus.communication_signal_out}, {13'b0, e.e_sig});
   endtask
   initial begin
      // memory image loaded while reset is held; outputs must read as reset values
      tbl.push_back(v(1, 0, 0, 0, 0, 0, 1,    3, 32'hABCD0003, 0, 0, 0, 0, 0));
      tbl.push_back(v(1, 0, 0, 0, 0, 0, 1,   14, 32'hFE000000, 0, 0, 0, 0, 0));
      tbl.push_back(v(1, 0, 0, 0, 0, 0, 1,   15, 32'h614A0038, 0, 0, 0, 0, 0));
      tbl.push_back(v(1, 0, 0, 0, 0, 0, 1,   16, 32'hFF012380, 0, 0, 0, 0, 0));
      tbl.push_back(v(1, 0, 0, 0, 0, 0, 1,   17, 32'hFE90F300, 0, 0, 0, 0, 0));
      tbl.push_back(v(1, 0, 0, 0, 0, 0, 1,   18, 32'h12345678, 0, 0, 0, 0, 0));
      tbl.push_back(v(1, 0, 0, 0, 0, 0, 1,   19, 32'hFC000000, 0, 0, 0, 0, 0));
      tbl.push_back(v(1, 0, 0, 0, 0, 0, 1,   20, 32'h0BADF00D, 0, 0, 0, 0, 0));
      tbl.push_back(v(1, 0, 0, 0, 0, 0, 1,   21, 32'hC0FFEE01, 0, 0, 0, 0, 0));
      tbl.push_back(v(1, 0, 0, 0, 0, 0, 1,   22, 32'h11112222, 0, 0, 0, 0, 0));
      tbl.push_back(v(1, 0, 0, 0, 0, 0, 1, 1023, 32'h00000077, 0, 0, 0, 0, 0));
      // first fetch from boot PC, then pc_in_0 (pc_in_1 parked at 3 to prove it is ignored)
      tbl.push_back(v(0,  0, 14, 0, 0, 0, 0, 0, 0, 15, 32'hFE000000, 0, 1, 19'h40000));
      tbl.push_back(v(0, 15,  3, 0, 0, 0, 0, 0, 0, 16, 32'h614A0038, 1, 0, 19'h0));
      tbl.push_back(v(0, 15,  3, 1, 0, 1, 0, 0, 0, 16, 32'h00000000, 1, 0, 19'h0));
      tbl.push_back(v(0, 16,  3, 0, 0, 0, 0, 0, 0, 17, 32'hFF012380, 0, 1, 19'h60247));
      for (int i = 0; i < 4; i++)
         tbl.push_back(v(0, 17, 3, 1, 0, 0, 0, 0, 0, 17, 32'hFF012380, 0, 1, 19'h60247));
      tbl.push_back(v(0, 17,  3, 0, 0, 0, 0, 0, 0, 18, 32'hFE90F300, 0, 1, 19'h521E6));
      tbl.push_back(v(0, 18,  3, 1, 1, 1, 0, 0, 0, 18, 32'h00000000, 0, 1, 19'h521E6));
      tbl.push_back(v(0, 18,  3, 0, 0, 0, 0, 0, 0, 19, 32'h12345678, 1, 0, 19'h0));
      tbl.push_back(v(0, 19,  3, 0, 0, 0, 0, 0, 0, 20, 32'hFC000000, 0, 1, 19'h0));
      foreach (tbl[i]) run(tbl[i]);
`ifdef INS_FETCH_END_HALT_EN
      for (int i = 0; i < 5; i++)
         run(v(0, 20 + i, 3, 0, 0, 0, 0, 0, 0, 20, 32'hFC000000, 0, 1, 19'h0));
`else
      run(v(0, 20, 3, 0, 0, 0, 0, 0, 0, 21, 32'h0BADF00D, 1, 0, 19'h0));
      run(v(0, 21, 3, 0, 0, 0, 0, 0, 0, 22, 32'hC0FFEE01, 1, 0, 19'h0));
`endif
      // reset with stall: reset wins, then refetch from boot PC with address wrap
      run(v(1, 21, 3, 1, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 19'h0));
      run(v(0, 0, 1027, 0, 0, 0, 0, 0, 0, 1028, 32'hABCD0003, 1, 0, 19'h0));
      run(v(0, 32'hFFFFFFFF, 3, 0, 0, 0, 0, 0, 0, 0, 32'h00000077, 1, 0, 19'h0));
      run(v(0, 22, 3, 0, 0, 0, 1, 22, 32'h33334444, 23, 32'h11112222, 1, 0, 19'h0));
      run(v(0, 22, 3, 0, 0, 0, 0, 0, 0, 23, 32'h33334444, 1, 0, 19'h0));
      run(v(0, 5, 3, 1, 0, 0, 1, 1029, 32'h00000055, 23, 32'h33334444, 1, 0, 19'h0));
      run(v(0, 5, 3, 0, 0, 0, 0, 0, 0, 6, 32'h00000055, 1, 0, 19'h0));
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/ins_fetch_unit.md
# ins_fetch_unit

Instruction fetch stage of the single-thread microprocessor. Selects the fetch PC (boot PC or the next PC returned by the memory stage), reads a 32-bit word from an internal word-addressed instruction memory, and registers the instruction and next PC for the downstream stages. Instructions with opcode 6'b111111 are communication instructions: they go to the communication unit, not to the control unit.

## Interface
- MEM_DEPTH, 1024: instruction memory depth in 32-bit words (power of two).
- clock  in  1: single clock, rising edge.
- reset  in  1: synchronous, active-high reset.
- pc_in_0  in  32: next PC fed back from the memory stage (normally equals npc_out).
- pc_in_1  in  32: boot/initial PC, used for the first fetch after reset.
- wait_for_next_in  in  1: communication-unit stall; holds all fetch state.
- freeze_pc_in  in  1: control-unit PC freeze; holds all fetch state.
- freeze_in  in  1: control-unit freeze; masks ins_out to zero.
- ins_wr_en  in  1: instruction memory write enable.
- ins_wr_addr  in  32: word address of write (low log2(MEM_DEPTH) bits used).
- ins_wr_data  in  32: instruction word to write.
- npc_out  out  32: registered fetched PC + 1.
- ins_out  out  32: registered fetched instruction, zero while freeze_in=1.
- cu_enable_out  out  1: registered; 1 when the held instruction is a regular instruction.
- communication_enable_out  out  1: registered; 1 when the held instruction has opcode 6'b111111.
- communication_signal_out  out  19: registered instr[25:7] of a communication instruction, else 0.

## Operation
- State registers: pc (32), pc_choice (1), halted (1), instruction register, npc_out, output flags.
- Fetch PC: pc_sel = pc_choice ? pc_in_1 : pc_in_0. Memory read is combinational: ins_wire = mem[pc_sel mod MEM_DEPTH] (address wraps).
- Advance when wait_for_next_in=0, freeze_pc_in=0, halted=0: pc<=pc_sel; instruction register<=ins_wire; npc_out<=pc_sel+1 (32-bit, wraps at 2^32); pc_choice<=0.
- Decode on ins_wire[31:26]: if 6'b111111, communication_enable_out<=1, communication_signal_out<=ins_wire[25:7], cu_enable_out<=0. Otherwise, communication_enable_out<=0, communication_signal_out<=0, cu_enable_out<=1.
- Communication field layout: [18:17] type (10 start, 11 stop, 00 end, 01 reserved), [16] dependency flag, [15:0] signal payload.
- End (type 00) advanced into the register sets halted=1. No further advance until reset. Outputs stay held.
- Stall: any hold condition freezes every register, so outputs repeat the same instruction and flags (communication_enable_out stays high during a wait).
- ins_out = freeze_in ? 32'b0 : instruction register. This is combinational. Other outputs are not affected by freeze_in.
- Memory write: synchronous on clock when ins_wr_en=1. Writes are accepted during reset and stalls. A read of the same address in the same cycle returns the old data.

## Timing
- Reset (synchronous): pc=0, pc_choice=1, halted=0, instruction register=0, npc_out=0, cu_enable_out=0, communication_enable_out=0, communication_signal_out=0. Memory contents are unchanged.
- Latency: one cycle from pc_sel to registered outputs. The first edge after reset releases fetches from pc_in_1.
- Back-to-back fetch: one instruction per cycle when pc_in_0 = npc_out.
- Simultaneous reset and stall: reset wins.
- Simultaneous wait_for_next_in and freeze_pc_in: single hold, with no extra effect.
- Reset mid-operation: the next fetch is again from pc_in_1, and halted clears.

## Configuration
- INS_FETCH_END_HALT_EN defined: End instruction sets halted as described.
- INS_FETCH_END_HALT_EN undefined: halted is always 0. End is reported like any communication instruction and fetch continues.

## Test plan
- Reset, then pc_in_1=14 with mem[14]=start-independent (32'hFE000000) -> after one edge: communication_enable_out=1, communication_signal_out=19'b10_0_0x0000, cu_enable_out=0, npc_out=15.
- Regular word 32'h614A0038 at address 15, freeze_in=0 -> ins_out=32'h614A0038, cu_enable_out=1, npc_out=16. With freeze_in=1 -> ins_out=0 and all other outputs unchanged.
- Hold wait_for_next_in=1 for 4 cycles on a stop instruction -> all outputs constant for 4 cycles. Release -> next address fetched on the following edge.
- Dependent start 32'hFE90F300 -> communication_signal_out[16]=1, [15:0]=16'h21E6.
- End word 32'hFC000000 with INS_FETCH_END_HALT_EN -> outputs frozen indefinitely. Reset -> refetch from pc_in_1.
- pc_sel=MEM_DEPTH+3 reads mem[3]. pc_sel=32'hFFFFFFFF gives npc_out=0.
